// File: rtl/pc_sequencer.sv
// Program-counter sequencer: arbitrates branch, interrupt entry/return, stalls and
// debug halt/step, and drives the PC's branch/stop controls from registered outputs.
module pc_sequencer #(
    parameter int                WIDTH      = 8,
    parameter logic [WIDTH-1:0]  IRQ_VECTOR = 8'hF0
) (
    input  logic             clk,
    input  logic             power,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_target,
    output logic             br_ack,
    input  logic             irq_req,
    input  logic             irq_en,
    output logic             irq_ack,
    input  logic             reti,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             step,
    input  logic             stall_req,
    input  logic [3:0]       stall_len,
    output logic             branch_en,
    output logic [WIDTH-1:0] branch_pc,
    output logic             stop_en,
    output logic             in_isr,
    output logic             halted,
    output logic [WIDTH-1:0] epc
);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT, S_STEP} state_t;

    state_t           state_q, state_d;
    logic             branch_en_q, branch_en_d;
    logic [WIDTH-1:0] branch_pc_q, branch_pc_d;
    logic             stop_en_q, stop_en_d;
    logic             br_ack_q, br_ack_d;
    logic             irq_ack_q, irq_ack_d;
    logic             in_isr_q, in_isr_d;
    logic             halted_q, halted_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [3:0]       cnt_q, cnt_d;

    // A new event is only taken once the previous branch/stop has reached the PC,
    // which keeps a still-held br_req from being accepted twice.
    logic accept;
    logic reti_ok, irq_ok;
    logic take_halt, take_reti, take_irq, take_br, take_stall;

    assign accept     = (state_q == S_RUN) && !branch_en_q && !stop_en_q;
    assign reti_ok    = reti && in_isr_q;
    assign irq_ok     = irq_req && irq_en && !in_isr_q;
    assign take_halt  = accept && halt_req;
    assign take_reti  = accept && !halt_req && reti_ok;
    assign take_irq   = accept && !halt_req && !reti_ok && irq_ok;
    assign take_br    = accept && !halt_req && !reti_ok && !irq_ok && br_req;
    assign take_stall = accept && !halt_req && !reti_ok && !irq_ok && !br_req && stall_req;

    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            state_q     <= S_RUN;
            branch_en_q <= 1'b0;
            branch_pc_q <= '0;
            stop_en_q   <= 1'b0;
            br_ack_q    <= 1'b0;
            irq_ack_q   <= 1'b0;
            in_isr_q    <= 1'b0;
            halted_q    <= 1'b0;
            epc_q       <= '0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            branch_en_q <= branch_en_d;
            branch_pc_q <= branch_pc_d;
            stop_en_q   <= stop_en_d;
            br_ack_q    <= br_ack_d;
            irq_ack_q   <= irq_ack_d;
            in_isr_q    <= in_isr_d;
            halted_q    <= halted_d;
            epc_q       <= epc_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (take_halt)       state_d = S_HALT;
                else if (take_stall) state_d = S_STALL;
            end
            S_STALL: begin
                if (halt_req)           state_d = S_HALT;
                else if (cnt_q == 4'd0) state_d = S_RUN;
            end
            S_HALT: begin
                if (resume)    state_d = S_RUN;
                else if (step) state_d = S_STEP;
            end
            S_STEP:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    // stop_en/halted follow the state being entered, so they line up with it after the edge.
    always_comb begin
        branch_en_d = take_reti || take_irq || take_br;
        br_ack_d    = take_br || (take_irq && br_req);
        irq_ack_d   = take_irq;
        branch_pc_d = branch_pc_q;
        if (take_reti)     branch_pc_d = epc_q;
        else if (take_irq) branch_pc_d = IRQ_VECTOR;
        else if (take_br)  branch_pc_d = br_target;
        in_isr_d = in_isr_q;
        if (take_irq)       in_isr_d = 1'b1;
        else if (take_reti) in_isr_d = 1'b0;
        epc_d = epc_q;
        if (take_irq) epc_d = br_req ? br_target : next_pc;
        stop_en_d = (state_d == S_HALT) || (state_d == S_STALL);
        halted_d  = (state_d == S_HALT) || (state_d == S_STEP);
        cnt_d = 4'd0;
        if (take_stall)
            cnt_d = (stall_len == 4'd0) ? 4'd0 : stall_len - 4'd1;
        else if (state_q == S_STALL && !halt_req && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    assign branch_en = branch_en_q;
    assign branch_pc = branch_pc_q;
    assign stop_en   = stop_en_q;
    assign br_ack    = br_ack_q;
    assign irq_ack   = irq_ack_q;
    assign in_isr    = in_isr_q;
    assign halted    = halted_q;
    assign epc       = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the sequencing rules.
module tb_pc_sequencer;

  localparam logic [7:0] IRQ_VEC = 8'hF0;
  localparam int M_RUN = 0, M_STALL = 1, M_HALT = 2, M_STEP = 3;

  logic       clk = 1'b0;
  logic       power;
  logic [7:0] next_pc, br_target, branch_pc, epc;
  logic       br_req, br_ack, irq_req, irq_en, irq_ack, reti;
  logic       halt_req, resume, step, stall_req;
  logic [3:0] stall_len;
  logic       branch_en, stop_en, in_isr, halted;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int         m_mode;
  int         m_left;
  logic       e_branch_en, e_stop, e_br_ack, e_irq_ack, e_in_isr, e_halted;
  logic [7:0] e_branch_pc, e_epc;

  logic [21:0] obs;
  assign obs = {branch_en, branch_pc, stop_en, br_ack, irq_ack, in_isr, halted, epc};

  pc_sequencer #(.WIDTH(8), .IRQ_VECTOR(8'hF0)) dut (
    .clk(clk), .power(power), .next_pc(next_pc),
    .br_req(br_req), .br_target(br_target), .br_ack(br_ack),
    .irq_req(irq_req), .irq_en(irq_en), .irq_ack(irq_ack), .reti(reti),
    .halt_req(halt_req), .resume(resume), .step(step),
    .stall_req(stall_req), .stall_len(stall_len),
    .branch_en(branch_en), .branch_pc(branch_pc), .stop_en(stop_en),
    .in_isr(in_isr), .halted(halted), .epc(epc)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] exp_vec();
    return {e_branch_en, e_branch_pc, e_stop, e_br_ack, e_irq_ack, e_in_isr, e_halted, e_epc};
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_left = 0;
    e_branch_en = 0; e_stop = 0; e_br_ack = 0; e_irq_ack = 0;
    e_in_isr = 0; e_halted = 0; e_branch_pc = 8'h00; e_epc = 8'h00;
  endtask

  // One clock edge of the sequencing rules; m_left counts stop cycles still owed.
  task automatic model_edge();
    bit open;
    open = (m_mode == M_RUN) && !e_branch_en && !e_stop;
    e_branch_en = 0; e_br_ack = 0; e_irq_ack = 0;
    case (m_mode)
      M_RUN: begin
        e_stop = 0; e_halted = 0;
        if (open) begin
          if (halt_req) begin
            m_mode = M_HALT; e_stop = 1; e_halted = 1;
          end else if (reti && e_in_isr) begin
            e_branch_en = 1; e_branch_pc = e_epc; e_in_isr = 0;
          end else if (irq_req && irq_en && !e_in_isr) begin
            e_branch_en = 1; e_branch_pc = IRQ_VEC; e_irq_ack = 1; e_in_isr = 1;
            e_br_ack = br_req;
            e_epc = br_req ? br_target : next_pc;
          end else if (br_req) begin
            e_branch_en = 1; e_branch_pc = br_target; e_br_ack = 1;
          end else if (stall_req) begin
            m_mode = M_STALL; e_stop = 1;
            m_left = (stall_len == 0) ? 1 : int'(stall_len);
          end
        end
      end
      M_STALL: begin
        m_left = m_left - 1;
        if (halt_req) begin
          m_mode = M_HALT; e_stop = 1; e_halted = 1; m_left = 0;
        end else if (m_left > 0) begin
          e_stop = 1;
        end else begin
          m_mode = M_RUN; e_stop = 0;
        end
      end
      M_HALT: begin
        if (resume) begin
          m_mode = M_RUN; e_stop = 0; e_halted = 0;
        end else if (step) begin
          m_mode = M_STEP; e_stop = 0; e_halted = 1;
        end else begin
          e_stop = 1; e_halted = 1;
        end
      end
      default: begin
        m_mode = M_HALT; e_stop = 1; e_halted = 1;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    br_req = 0; irq_req = 0; irq_en = 0; reti = 0; halt_req = 0;
    resume = 0; step = 0; stall_req = 0; stall_len = 4'd0;
  endtask

  task automatic test_reset();
    power = 0; clear_inputs(); next_pc = 8'h00; br_target = 8'h00;
    model_reset();
    #3;
    n_checks++;
    if (obs !== 22'd0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, 22'd0);
    end
    #20 power = 1;
    tick();
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs(); tick();
    stall_req = 1; stall_len = 4'd5;
    tick();
    stall_req = 0;
    n_checks++;
    if (obs !== exp_vec() || stop_en !== 1'b1) begin
      n_fail++; $display("FAIL stall_enter: got %h expected %h", obs, exp_vec());
    end
    tick();
    #2 power = 0;
    #1;
    model_reset();
    n_checks++;
    if (obs !== 22'd0) begin
      n_fail++; $display("FAIL reset_mid_stall: got %h expected %h", obs, 22'd0);
    end
    #2 power = 1;
    tick();
    n_checks++;
    if (obs !== exp_vec() || stop_en !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_run: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_branch();
    int acks, pulses;
    clear_inputs(); tick();
    br_req = 1; br_target = 8'h3C; acks = 0; pulses = 0;
    tick();
    acks += int'(br_ack); pulses += int'(branch_en);
    n_checks++;
    if (obs !== exp_vec() || branch_pc !== 8'h3C || br_ack !== 1'b1) begin
      n_fail++; $display("FAIL branch_accept: got %h expected %h", obs, exp_vec());
    end
    tick();
    acks += int'(br_ack); pulses += int'(branch_en);
    br_req = 0;
    tick();
    acks += int'(br_ack); pulses += int'(branch_en);
    n_checks++;
    if (acks != 1 || pulses != 1 || branch_pc !== 8'h3C) begin
      n_fail++; $display("FAIL branch_single_accept: got acks=%0d pulses=%0d pc=%h expected 1 1 3c",
                         acks, pulses, branch_pc);
    end
  endtask

  task automatic test_irq_vs_branch();
    clear_inputs(); tick();
    irq_req = 1; irq_en = 1; br_req = 1; br_target = 8'h20; next_pc = 8'h55;
    tick();
    clear_inputs();
    n_checks++;
    if (obs !== exp_vec() || branch_pc !== 8'hF0 || irq_ack !== 1'b1 || br_ack !== 1'b1 ||
        epc !== 8'h20 || in_isr !== 1'b1) begin
      n_fail++; $display("FAIL irq_with_branch: got %h expected %h", obs, exp_vec());
    end
    tick();
    reti = 1;
    tick();
    reti = 0;
    n_checks++;
    if (obs !== exp_vec() || branch_en !== 1'b1 || branch_pc !== 8'h20 || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL reti_return: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_irq_wrap();
    int early, seen;
    clear_inputs(); tick(); tick();
    next_pc = 8'hFF; irq_req = 1; irq_en = 1;
    tick();
    n_checks++;
    if (obs !== exp_vec() || epc !== 8'hFF || irq_ack !== 1'b1) begin
      n_fail++; $display("FAIL irq_epc_wrap: got %h expected %h", obs, exp_vec());
    end
    early = 0;
    for (int i = 0; i < 4; i++) begin
      next_pc = 8'($urandom_range(0, 255));
      tick();
      early += int'(irq_ack);
    end
    n_checks++;
    if (early != 0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL irq_nested_blocked: got acks=%0d obs=%h expected 0 %h", early, obs, exp_vec());
    end
    reti = 1;
    tick();
    reti = 0;
    n_checks++;
    if (obs !== exp_vec() || branch_pc !== 8'hFF || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL reti_to_wrap: got %h expected %h", obs, exp_vec());
    end
    seen = 0;
    for (int i = 0; i < 4 && seen == 0; i++) begin
      tick();
      seen = int'(irq_ack);
    end
    n_checks++;
    if (seen != 1 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL irq_pending_taken: got ack=%0d obs=%h expected 1 %h", seen, obs, exp_vec());
    end
    clear_inputs(); tick();
    reti = 1; tick(); reti = 0;
  endtask

  task automatic test_stall_lengths();
    int cnt, want;
    for (int k = 0; k < 2; k++) begin
      clear_inputs(); tick();
      stall_req = 1; stall_len = (k == 0) ? 4'd0 : 4'd4;
      want = (k == 0) ? 1 : 4;
      tick();
      stall_req = 0;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
        n_checks++;
        if (obs !== exp_vec()) begin
          n_fail++; $display("FAIL stall_cycle: got %h expected %h", obs, exp_vec());
        end
        if (stop_en) cnt++;
        else break;
        tick();
      end
      n_checks++;
      if (cnt != want) begin
        n_fail++; $display("FAIL stall_len_%0d: got %0d stop cycles expected %0d", want, cnt, want);
      end
    end
  endtask

  task automatic test_debug();
    int acks;
    clear_inputs(); tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    n_checks++;
    if (obs !== exp_vec() || stop_en !== 1'b1 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_enter: got %h expected %h", obs, exp_vec());
    end
    tick();
    step = 1;
    tick();
    step = 0;
    n_checks++;
    if (obs !== exp_vec() || stop_en !== 1'b0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL step_open: got %h expected %h", obs, exp_vec());
    end
    tick();
    n_checks++;
    if (obs !== exp_vec() || stop_en !== 1'b1 || halted !== 1'b1) begin
      n_fail++; $display("FAIL step_rehalt: got %h expected %h", obs, exp_vec());
    end
    irq_req = 1; irq_en = 1; next_pc = 8'h77; acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acks += int'(irq_ack);
    end
    n_checks++;
    if (acks != 0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL irq_in_halt: got acks=%0d obs=%h expected 0 %h", acks, obs, exp_vec());
    end
    resume = 1; step = 1;
    tick();
    resume = 0; step = 0;
    n_checks++;
    if (obs !== exp_vec() || stop_en !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL resume_wins: got %h expected %h", obs, exp_vec());
    end
    tick();
    n_checks++;
    if (obs !== exp_vec() || irq_ack !== 1'b1 || branch_pc !== 8'hF0 || epc !== 8'h77) begin
      n_fail++; $display("FAIL irq_after_resume: got %h expected %h", obs, exp_vec());
    end
    clear_inputs(); tick();
    reti = 1; tick(); reti = 0;
    n_checks++;
    if (obs !== exp_vec() || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL debug_reti: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      next_pc   = 8'($urandom_range(0, 255));
      br_req    = ($urandom_range(0, 2) == 0);
      br_target = 8'($urandom_range(0, 255));
      irq_req   = ($urandom_range(0, 5) == 0);
      irq_en    = ($urandom_range(0, 3) != 0);
      reti      = ($urandom_range(0, 4) == 0);
      halt_req  = ($urandom_range(0, 24) == 0);
      resume    = ($urandom_range(0, 4) == 0);
      step      = ($urandom_range(0, 3) == 0);
      stall_req = ($urandom_range(0, 5) == 0);
      stall_len = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid_stall();
    test_branch();
    test_irq_vs_branch();
    test_irq_wrap();
    test_stall_lengths();
    test_debug();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
